// File: rtl/accel_sequencer.sv
// accel_sequencer: configures an ADXL345 over i2c_controller, then reads the six
// axis-data registers at a fixed tick rate and publishes X/Y/Z samples atomically.
// Build option: ACCEL_DEVID_CHECK_EN adds a DEVID (0x00 == 0xE5) read before configuration.
module accel_sequencer #(
  parameter int unsigned SYS_CLK_SPEED  = 50000000,
  parameter int unsigned SAMPLE_RATE_HZ = 100,
  parameter logic [6:0]  SENSOR_ADDR    = 7'h1D,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  DEV_ADDR,
  output logic [7:0]  REG_ADDR,
  output logic        R_W,
  output logic [7:0]  WRITE_DATA,
  input  logic [7:0]  READ_DATA,
  output logic        start_i2c_comms,
  input  logic        i2c_comms_finished,
  input  logic        ready,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        error
);

  localparam int unsigned TICK_PERIOD = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
  localparam int unsigned TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned TO_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] DATA_BASE = 8'h32;
  localparam logic [2:0] LAST_BYTE = 3'd5;
  localparam logic [1:0] LAST_INIT = 2'd2;

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] INIT_ISSUE = 4'd1;
  localparam logic [3:0] INIT_WAIT  = 4'd2;
  localparam logic [3:0] WAIT_TICK  = 4'd3;
  localparam logic [3:0] RD_ISSUE   = 4'd4;
  localparam logic [3:0] RD_WAIT    = 4'd5;
  localparam logic [3:0] PUBLISH    = 4'd6;
  localparam logic [3:0] ERROR      = 4'd7;
`ifdef ACCEL_DEVID_CHECK_EN
  localparam logic [3:0] ID_ISSUE   = 4'd8;
  localparam logic [3:0] ID_WAIT    = 4'd9;
  localparam logic [7:0] DEVID_REG  = 8'h00;
  localparam logic [7:0] DEVID_VAL  = 8'hE5;
`endif

  logic [3:0]        state, state_d;
  logic [1:0]        init_idx, init_idx_d;
  logic [2:0]        rd_idx, rd_idx_d;
  logic [47:0]       shadow, shadow_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic [TICK_W-1:0] tick_cnt;
  logic              pending, clear_pending;
  logic              timeout_hit, tick_wrap;
  logic [7:0]        reg_addr_d, write_data_d;
  logic              r_w_d, start_d, sample_valid_d, init_done_d, error_d;
  logic [15:0]       accel_x_d, accel_y_d, accel_z_d;

  // Configuration table: {register, value}
  function automatic logic [15:0] init_entry(input logic [1:0] idx);
    logic [15:0] e;
    case (idx)
      2'd0:    e = {8'h31, 8'h08};
      2'd1:    e = {8'h2C, 8'h0A};
      default: e = {8'h2D, 8'h08};
    endcase
    return e;
  endfunction

  assign timeout_hit = (to_cnt == TO_LAST);
  assign tick_wrap   = init_done && (tick_cnt == TICK_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_d        = state;
    init_idx_d     = init_idx;
    rd_idx_d       = rd_idx;
    shadow_d       = shadow;
    to_cnt_d       = to_cnt;
    reg_addr_d     = REG_ADDR;
    r_w_d          = R_W;
    write_data_d   = WRITE_DATA;
    start_d        = 1'b0;
    sample_valid_d = 1'b0;
    init_done_d    = init_done;
    error_d        = error;
    accel_x_d      = accel_x;
    accel_y_d      = accel_y;
    accel_z_d      = accel_z;
    clear_pending  = 1'b0;

    case (state)
      IDLE: begin
`ifdef ACCEL_DEVID_CHECK_EN
        reg_addr_d   = DEVID_REG;
        r_w_d        = 1'b1;
        write_data_d = 8'h00;
        state_d      = ID_ISSUE;
`else
        init_idx_d                 = 2'd0;
        {reg_addr_d, write_data_d} = init_entry(2'd0);
        r_w_d                      = 1'b0;
        state_d                    = INIT_ISSUE;
`endif
      end

`ifdef ACCEL_DEVID_CHECK_EN
      ID_ISSUE: begin
        if (ready) begin
          start_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = ID_WAIT;
        end
      end

      ID_WAIT: begin
        if (i2c_comms_finished) begin
          if (READ_DATA == DEVID_VAL) begin
            init_idx_d                 = 2'd0;
            {reg_addr_d, write_data_d} = init_entry(2'd0);
            r_w_d                      = 1'b0;
            state_d                    = INIT_ISSUE;
          end else begin
            error_d = 1'b1;
            state_d = ERROR;
          end
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = ERROR;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end
`endif

      INIT_ISSUE: begin
        if (ready) begin
          start_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = INIT_WAIT;
        end
      end

      INIT_WAIT: begin
        if (i2c_comms_finished) begin
          if (init_idx == LAST_INIT) begin
            init_done_d = 1'b1;
            state_d     = WAIT_TICK;
          end else begin
            init_idx_d                 = init_idx + 2'd1;
            {reg_addr_d, write_data_d} = init_entry(init_idx + 2'd1);
            r_w_d                      = 1'b0;
            state_d                    = INIT_ISSUE;
          end
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = ERROR;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end

      WAIT_TICK: begin
        if (pending) begin
          clear_pending = 1'b1;
          rd_idx_d      = 3'd0;
          reg_addr_d    = DATA_BASE;
          r_w_d         = 1'b1;
          write_data_d  = 8'h00;
          state_d       = RD_ISSUE;
        end
      end

      RD_ISSUE: begin
        if (ready) begin
          start_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (i2c_comms_finished) begin
          shadow_d[{rd_idx, 3'b000} +: 8] = READ_DATA;
          if (rd_idx == LAST_BYTE) begin
            state_d = PUBLISH;
          end else begin
            rd_idx_d   = rd_idx + 3'd1;
            reg_addr_d = DATA_BASE + 8'(rd_idx + 3'd1);
            state_d    = RD_ISSUE;
          end
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = ERROR;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end

      PUBLISH: begin
        accel_x_d      = shadow[15:0];
        accel_y_d      = shadow[31:16];
        accel_z_d      = shadow[47:32];
        sample_valid_d = 1'b1;
        state_d        = WAIT_TICK;
      end

      ERROR: begin
        error_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      init_idx        <= 2'd0;
      rd_idx          <= 3'd0;
      shadow          <= '0;
      to_cnt          <= '0;
      DEV_ADDR        <= SENSOR_ADDR;
      REG_ADDR        <= 8'h00;
      R_W             <= 1'b0;
      WRITE_DATA      <= 8'h00;
      start_i2c_comms <= 1'b0;
      sample_valid    <= 1'b0;
      init_done       <= 1'b0;
      error           <= 1'b0;
      accel_x         <= 16'h0000;
      accel_y         <= 16'h0000;
      accel_z         <= 16'h0000;
    end else begin
      state           <= state_d;
      init_idx        <= init_idx_d;
      rd_idx          <= rd_idx_d;
      shadow          <= shadow_d;
      to_cnt          <= to_cnt_d;
      DEV_ADDR        <= SENSOR_ADDR;
      REG_ADDR        <= reg_addr_d;
      R_W             <= r_w_d;
      WRITE_DATA      <= write_data_d;
      start_i2c_comms <= start_d;
      sample_valid    <= sample_valid_d;
      init_done       <= init_done_d;
      error           <= error_d;
      accel_x         <= accel_x_d;
      accel_y         <= accel_y_d;
      accel_z         <= accel_z_d;
    end
  end

  // Sample tick: free-running once configured; ticks during a burst coalesce into pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      if (!init_done) begin
        tick_cnt <= '0;
      end else if (tick_wrap) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (tick_wrap) begin
        pending <= 1'b1;
      end else if (clear_pending) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
